instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Upstream neighbour of the pipeline register bank; its registered instruction output drives `fetch_in` of the decode/pipeline-register stage.
- Owns the PC and issues in-order 16-bit word fetches to instruction memory over a req/ready, rvalid handshake.
- Buffers returned words in a small prefetch FIFO and honours the pipeline's stall, clear/branch-redirect and sleep controls.

Parameters:
- RESET_PC, 16'h0000: PC loaded on reset; bit 0 must be 0.
- BUF_DEPTH, 2: prefetch FIFO entries; also the cap on outstanding requests plus buffered words.

Ports:
- clk  in  1  clock.
- reset_fetch  in  1  synchronous, active-high reset.
- stall_in  in  8  hold output when any bit is set (same encoding the pipeline registers use).
- redirect_in  in  1  branch taken or prediction failed; flush and refetch.
- redirect_pc  in  16  new PC, valid with redirect_in; bit 0 ignored (forced 0).
- sleep_in  in  1  pulse: stop issuing fetches (SLP executed).
- wake_in  in  1  pulse: resume issuing from the current PC.
- imem_req  out  1  fetch request.
- imem_addr  out  16  byte address, always even.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, minimum 1 cycle after acceptance.
- imem_rdata  in  16  instruction word.
- fetch_o  out  16  instruction to decode.
- fetch_pc_o  out  16  address of fetch_o.
- fetch_valid_o  out  1  fetch_o holds a real instruction.

Behaviour:
- Reset, synchronous and active-high:
  - pc = RESET_PC.
  - FIFO empty, outstanding = 0, drop_cnt = 0, state = RUN.
  - fetch_o = 0, fetch_pc_o = 0, fetch_valid_o = 0, imem_req = 0.
  - In-flight memory responses at reset are counted by no one, so the memory interface is reset together with this block.
- FSM states:
  - RUN: issue when permitted.
  - HALT: no issue; entered on sleep_in, left to RUN on wake_in.
  - Redirect or reset in HALT returns to RUN.
- Issue rule:
  - imem_req = (state == RUN) && !redirect_in && (outstanding + fifo_count < BUF_DEPTH).
  - imem_addr = pc.
  - On req && ready: pc += 2, wrapping 16'hFFFE -> 16'h0000, and outstanding++.
- Response rule: on rvalid, outstanding--.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Else if the FIFO is empty, the output is free (not stalled, or fetch_valid_o = 0) and the word is not discarded: bypass straight into the output register.
  - Otherwise push the word, tagged with its PC, into the FIFO.
- Output register:
  - Any stall bit set: hold fetch_o, fetch_pc_o and fetch_valid_o.
  - Not stalled: load the FIFO head (pop), or the bypass word, with valid = 1; if neither is available, valid = 0.
- Latency: with a zero-wait memory (ready = 1, rvalid one cycle after acceptance), the first word is visible with fetch_valid_o = 1 two cycles after the first cycle out of reset.
  - Sustained throughput is one instruction per cycle.
- Redirect cycle:
  - FIFO flushed, fetch_valid_o = 0.
  - pc = redirect_pc & 16'hFFFE.
  - drop_cnt = outstanding minus any response arriving that same cycle, and that response is discarded.
  - No request is issued that cycle; the target is requested the next cycle.
  - Redirect overrides stall.
- Sleep:
  - Responses still outstanding drain into the FIFO.
  - Sleep and redirect in the same cycle: the redirect PC is taken and state = HALT.
  - sleep_in and wake_in together: wake wins (state RUN).
- FIFO full: cannot overflow, because the issue rule reserves a slot for every outstanding request.

Decomposition:
- Shared package `xm23_pkg`:
  - INSTR_W = 16, ADDR_W = 16, PC_STEP = 2.
  - Fetch FSM enum `fetch_state_t` {RUN, HALT}.
  - Struct `fetch_entry_t` {instr, pc}.
- One sub-module: `fetch_fifo` (parameterised depth, push/pop/flush, count output).

Test Plan:
1. Reset release, zero-wait memory returning rdata = addr ^ 16'hA5A5:
   - imem_addr = 0, 2, 4, … on consecutive cycles.
   - fetch_valid_o first high 2 cycles after release, with fetch_pc_o = 0 and fetch_o = 16'hA5A5.
   - One instruction per cycle afterwards.
2. stall_in = 8'h04 for 3 cycles during streaming:
   - fetch_o/fetch_pc_o frozen.
   - At most BUF_DEPTH outstanding + buffered words.
   - No word lost or duplicated after release.
3. Memory latency 3 cycles, redirect_in with redirect_pc = 16'h0101 while 2 requests are outstanding:
   - Both stale responses discarded.
   - Next imem_addr = 16'h0100.
   - First valid output has fetch_pc_o = 16'h0100.
4. Redirect asserted in the same cycle as a response and as stall:
   - The response is dropped.
   - fetch_valid_o = 0 the next cycle.
   - No stale PC ever appears at the output.
5. sleep_in with 1 request outstanding:
   - imem_req low until wake_in.
   - The outstanding word is delivered.
   - After wake, fetch resumes at the next sequential PC.
6. PC at 16'hFFFE:
   - Next imem_addr = 16'h0000.
   - reset_fetch asserted mid-stream clears fetch_valid_o and restarts at RESET_PC.

Source files
------------

// File: rtl/xm23_pkg.sv
// Shared types and constants for the XM23 fetch front end.
//   INSTR_W / ADDR_W : instruction and byte-address widths
//   PC_STEP          : byte increment between sequential instruction words
//   fetch_state_t    : fetch sequencer states
//   fetch_entry_t    : prefetch buffer entry (instruction word plus its PC)
package xm23_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Sequential successor; the 16-bit add wraps 16'hFFFE to 16'h0000.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer for fetched instruction words tagged with their PC.
// Ports:
//   clk, reset_fetch     : clock, synchronous active-high reset
//   flush                : discard all entries (wins over push/pop)
//   push, push_instr/pc  : write one entry at the tail
//   pop                  : drop the head entry
//   head_instr/pc        : current head entry (meaningful when !empty)
//   count, empty         : occupancy
// Push and pop may occur in the same cycle. The caller guarantees push never
// hits a full buffer and pop never hits an empty one.
module fetch_fifo
    import xm23_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_fetch,
    input  logic               flush,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [CNT_W-1:0]   count,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset_fetch || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= '{instr: push_instr, pc: push_pc};
    end

    assign head_instr = mem[rd_ptr].instr;
    assign head_pc    = mem[rd_ptr].pc;
    assign empty      = (count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches over a
// req/ready + rvalid handshake, buffers returned words and presents one
// registered instruction per cycle to the decode pipeline register.
// Ports:
//   clk, reset_fetch          : clock, synchronous active-high reset
//   stall_in[7:0]             : any bit set holds the output register
//   redirect_in, redirect_pc  : flush and refetch from redirect_pc (bit 0 forced 0)
//   sleep_in, wake_in         : stop / resume issuing (wake wins if both)
//   imem_req/addr/ready       : request channel
//   imem_rvalid/rdata         : in-order response channel
//   fetch_o/fetch_pc_o/fetch_valid_o : instruction to decode
//
// state | meaning
// RUN   | requests issued whenever buffer space allows
// HALT  | no new requests; outstanding responses still drain
module instruction_fetch
    import xm23_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_fetch,
    input  logic [7:0]         stall_in,
    input  logic               redirect_in,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               sleep_in,
    input  logic               wake_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] fetch_o,
    output logic [ADDR_W-1:0]  fetch_pc_o,
    output logic               fetch_valid_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

    fetch_state_t       state, state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  resp_pc;     // PC of the next response that will be kept
    logic [ADDR_W-1:0]  target_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   fifo_count;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               fifo_empty;
    logic               stalled, room, issue, keep_word, bypass, fifo_push, fifo_pop;

    always_comb begin
        stalled   = |stall_in;
        target_pc = redirect_pc & ~ADDR_W'(1);
        // Every outstanding request already owns a buffer slot, so the FIFO
        // can never overflow.
        room      = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_L;
        imem_req  = !reset_fetch && (state == RUN) && !redirect_in && room;
        imem_addr = pc;
        issue     = imem_req && imem_ready;
        keep_word = imem_rvalid && (drop_cnt == '0) && !redirect_in;
        bypass    = keep_word && fifo_empty && (!stalled || !fetch_valid_o);
        fifo_push = keep_word && !bypass;
        fifo_pop  = !redirect_in && !stalled && !fifo_empty;
    end

    always_comb begin
        state_next = state;
        if (wake_in)          state_next = RUN;
        else if (sleep_in)    state_next = HALT;
        else if (redirect_in) state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset_fetch) begin
            state         <= RUN;
            pc            <= RESET_PC & ~ADDR_W'(1);
            resp_pc       <= RESET_PC & ~ADDR_W'(1);
            outstanding   <= '0;
            drop_cnt      <= '0;
            fetch_o       <= '0;
            fetch_pc_o    <= '0;
            fetch_valid_o <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);

            if (redirect_in) begin
                // Everything still in flight belongs to the old path.
                pc            <= target_pc;
                resp_pc       <= target_pc;
                drop_cnt      <= outstanding - CNT_W'(imem_rvalid);
                fetch_valid_o <= 1'b0;
            end else begin
                if (issue)                       pc       <= next_pc(pc);
                if (keep_word)                   resp_pc  <= next_pc(resp_pc);
                if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);

                // A bubble may be filled by a bypassed word even while stalled.
                if (bypass) begin
                    fetch_o       <= imem_rdata;
                    fetch_pc_o    <= resp_pc;
                    fetch_valid_o <= 1'b1;
                end else if (!stalled) begin
                    if (fifo_pop) begin
                        fetch_o    <= head_instr;
                        fetch_pc_o <= head_pc;
                    end
                    fetch_valid_o <= fifo_pop;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .reset_fetch (reset_fetch),
        .flush       (redirect_in),
        .push        (fifo_push),
        .push_instr  (imem_rdata),
        .push_pc     (resp_pc),
        .pop         (fifo_pop),
        .head_instr  (head_instr),
        .head_pc     (head_pc),
        .count       (fifo_count),
        .empty       (fifo_empty)
    );

endmodule
